// File: rtl/cache_pkg.sv
// +-----------------------------------------------------------------------+
// | cache_pkg: shared state encoding and default geometry for the fill    |
// | controller.                            Revision: 1.0                  |
// +-----------------------------------------------------------------------+
`default_nettype none

package cache_pkg;

  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned WORDS_DEF      = 8;
  localparam int unsigned WORD_BYTES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } fill_state_e;

endpackage

`default_nettype wire

// File: rtl/cache_word_counter.sv
// +-----------------------------------------------------------------------+
// | cache_word_counter: word counter with synchronous clear (priority)    |
// | and count enable.                      Revision: 1.0                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module cache_word_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
// +-----------------------------------------------------------------------+
// | cache_fill_ctrl: miss handling FSM -- optional dirty-victim write-back |
// | (CACHE_FILL_WB_EN), block fill, tag update.   Revision: 1.0           |
// +-----------------------------------------------------------------------+
`default_nettype none

module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WORDS      = WORDS_DEF,
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] main_memory_address,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic              fill_done
);

  localparam int OFF_W = $clog2(WORDS * WORD_BYTES);
  localparam int WB_SH = $clog2(WORD_BYTES);
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  WORDS_C   = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(WORDS - 1);

  function automatic logic [ADDR_W-1:0] word_off(input logic [CNT_W-1:0] c);
    return ADDR_W'(c) << WB_SH;
  endfunction

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] miss_base_q, miss_base_d;
  logic [CNT_W-1:0]  iss_cnt, ret_cnt;
  logic              cnt_clr, iss_en, ret_en;
  logic              accept, iss_open, ret_open;
  logic              wb_go, wr_active;
  logic [ADDR_W-1:0] wr_addr;

  assign accept   = (state_q == ST_IDLE) && miss_detected;
  assign iss_open = iss_cnt < WORDS_C;
  assign ret_open = ret_cnt < WORDS_C;

`ifdef CACHE_FILL_WB_EN
  logic [ADDR_W-1:0] victim_base_q, victim_base_d;
  logic              victim_dirty_q, victim_dirty_d;

  always_comb begin
    victim_base_d  = victim_base_q;
    victim_dirty_d = victim_dirty_q;
    if (accept) begin
      victim_base_d  = victim_address & BASE_MASK;
      victim_dirty_d = victim_dirty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      victim_base_q  <= '0;
      victim_dirty_q <= 1'b0;
    end else begin
      victim_base_q  <= victim_base_d;
      victim_dirty_q <= victim_dirty_d;
    end
  end

  assign wb_go     = victim_dirty;
  assign wr_active = (state_q == ST_WB) && victim_dirty_q;
  assign wr_addr   = victim_base_q + word_off(iss_cnt);
`else
  logic unused_victim;
  assign unused_victim = ^{victim_dirty, victim_address};
  assign wb_go     = 1'b0;
  assign wr_active = 1'b0;
  assign wr_addr   = '0;
`endif

  always_comb begin
    state_d     = state_q;
    miss_base_d = miss_base_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_detected) begin
          miss_base_d = miss_address & BASE_MASK;
          state_d     = wb_go ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        if (iss_cnt == LAST_C) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (memory_data_valid && ret_open && (ret_cnt == LAST_C)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      miss_base_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_base_q <= miss_base_d;
    end
  end

  // Counters are held clear in IDLE and re-cleared on the WB-to-FILL hand-off.
  assign cnt_clr = (state_q == ST_IDLE) || ((state_q == ST_WB) && (iss_cnt == LAST_C));
  assign iss_en  = ((state_q == ST_FILL) && iss_open) || (state_q == ST_WB);
  assign ret_en  = (state_q == ST_FILL) && memory_data_valid && ret_open;

  cache_word_counter #(.WIDTH(CNT_W)) u_iss_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (iss_en),
    .count  (iss_cnt)
  );

  cache_word_counter #(.WIDTH(CNT_W)) u_ret_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (ret_en),
    .count  (ret_cnt)
  );

  always_comb begin
    fsm_busy            = !rst && ((state_q != ST_IDLE) || miss_detected);
    mem_rd_req          = (state_q == ST_FILL) && iss_open;
    mem_wr_req          = wr_active;
    write_data_array    = ret_en;
    write_tag_array     = (state_q == ST_DONE);
    fill_done           = (state_q == ST_DONE);
    main_memory_address = '0;
    memory_address      = '0;
    if (mem_rd_req) begin
      main_memory_address = miss_base_q + word_off(iss_cnt);
    end else if (wr_active) begin
      main_memory_address = wr_addr;
    end
    if (ret_en) begin
      memory_address = miss_base_q + word_off(ret_cnt);
    end else if (wr_active) begin
      memory_address = miss_base_q + word_off(iss_cnt);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_cache_fill_ctrl: randomized bench for cache_fill_ctrl with a       |
// | transaction-level expectation model.   Revision: 1.0                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected, victim_dirty, memory_data_valid;
  logic [15:0] miss_address, victim_address;
  logic        fsm_busy, mem_rd_req, mem_wr_req, write_data_array, write_tag_array, fill_done;
  logic [15:0] main_memory_address, memory_address;

  logic        s_miss, s_vdirty, s_valid;
  logic [15:0] s_addr, s_vaddr;
  logic        s_busy, s_rd, s_wr, s_wda, s_tag, s_done;
  logic [15:0] s_maddr, s_caddr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_fill_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .miss_detected       (miss_detected),
    .miss_address        (miss_address),
    .victim_dirty        (victim_dirty),
    .victim_address      (victim_address),
    .memory_data_valid   (memory_data_valid),
    .fsm_busy            (fsm_busy),
    .mem_rd_req          (mem_rd_req),
    .mem_wr_req          (mem_wr_req),
    .main_memory_address (main_memory_address),
    .memory_address      (memory_address),
    .write_data_array    (write_data_array),
    .write_tag_array     (write_tag_array),
    .fill_done           (fill_done)
  );

  cache_fill_ctrl #(.ADDR_W(16), .WORDS(4), .WORD_BYTES(4)) dut4 (
    .clk                 (clk),
    .rst                 (rst),
    .miss_detected       (s_miss),
    .miss_address        (s_addr),
    .victim_dirty        (s_vdirty),
    .victim_address      (s_vaddr),
    .memory_data_valid   (s_valid),
    .fsm_busy            (s_busy),
    .mem_rd_req          (s_rd),
    .mem_wr_req          (s_wr),
    .main_memory_address (s_maddr),
    .memory_address      (s_caddr),
    .write_data_array    (s_wda),
    .write_tag_array     (s_tag),
    .fill_done           (s_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, fsm_busy, 0);
    chk({tag, ".rd"}, mem_rd_req, 0);
    chk({tag, ".wr"}, mem_wr_req, 0);
    chk({tag, ".maddr"}, main_memory_address, 0);
    chk({tag, ".caddr"}, memory_address, 0);
    chk({tag, ".wda"}, write_data_array, 0);
    chk({tag, ".tag"}, write_tag_array, 0);
    chk({tag, ".done"}, fill_done, 0);
  endtask

  // Scramble the inputs the controller must not depend on after latching.
  task automatic scramble(input bit disturb);
    miss_address      = 16'($urandom);
    victim_address    = 16'($urandom);
    victim_dirty      = 1'($urandom);
    miss_detected     = disturb ? 1'($urandom) : 1'b0;
  endtask

  // Expected behaviour of one miss, built from the block geometry (8 words
  // of 2 bytes): optional 8-cycle write-back, 8 reads, 8 in-order writes on
  // valid cycles, one completion cycle, then idle.
  task automatic run_miss(input logic [15:0] maddr, input logic [15:0] vaddr, input bit dirty,
                          input int mode, input bit disturb, input int rst_after);
    int  mbase, vbase, rets, j;
    bit  wb_on, v, aborted;
    mbase = int'(maddr) & 32'hFFF0;
    vbase = int'(vaddr) & 32'hFFF0;
`ifdef CACHE_FILL_WB_EN
    wb_on = dirty;
`else
    wb_on = 1'b0;
`endif
    @(negedge clk);
    miss_detected = 1'b1; miss_address = maddr; victim_address = vaddr; victim_dirty = dirty;
    memory_data_valid = 1'($urandom);
    #2;
    chk("accept.busy", fsm_busy, 1);
    chk("accept.rd", mem_rd_req, 0);
    chk("accept.wda", write_data_array, 0);
    @(posedge clk);
    if (wb_on) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        scramble(disturb);
        memory_data_valid = 1'($urandom);
        #2;
        chk("wb.busy", fsm_busy, 1);
        chk("wb.wr", mem_wr_req, 1);
        chk("wb.rd", mem_rd_req, 0);
        chk("wb.maddr", main_memory_address, vbase + k * 2);
        chk("wb.caddr", memory_address, mbase + k * 2);
        chk("wb.wda", write_data_array, 0);
        @(posedge clk);
      end
    end
    rets = 0; j = 0; aborted = 1'b0;
    while (rets < 8 && j < 200) begin
      case (mode)
        0:       v = (j >= 4) && (j < 12);
        1:       v = (j % 3) == 0;
        default: v = 1'($urandom);
      endcase
      @(negedge clk);
      scramble(disturb);
      memory_data_valid = v;
      #2;
      chk("fill.busy", fsm_busy, 1);
      chk("fill.wr", mem_wr_req, 0);
      chk("fill.rd", mem_rd_req, (j < 8) ? 1 : 0);
      if (j < 8) chk("fill.maddr", main_memory_address, mbase + j * 2);
      chk("fill.wda", write_data_array, v);
      if (v) chk("fill.caddr", memory_address, mbase + rets * 2);
      chk("fill.done", fill_done, 0);
      if (v) rets++;
      j++;
      @(posedge clk);
      if (rst_after > 0 && rets == rst_after) begin
        aborted = 1'b1;
        break;
      end
    end
    if (j >= 200) chk("fill.timeout", 0, 1);
    if (aborted) begin
      @(negedge clk);
      rst = 1'b1; miss_detected = 1'b1; memory_data_valid = 1'b1;
      #2;
      chk_all_zero("midreset");
      @(negedge clk);
      rst = 1'b0; miss_detected = 1'b0; memory_data_valid = 1'b0;
      return;
    end
    @(negedge clk);
    scramble(disturb);
    memory_data_valid = 1'($urandom);
    #2;
    chk("done.busy", fsm_busy, 1);
    chk("done.tag", write_tag_array, 1);
    chk("done.pulse", fill_done, 1);
    chk("done.rd", mem_rd_req, 0);
    chk("done.wda", write_data_array, 0);
    @(posedge clk);
    @(negedge clk);
    miss_detected = 1'b0; memory_data_valid = 1'($urandom);
    #2;
    chk("idle.busy", fsm_busy, 0);
    chk("idle.done", fill_done, 0);
    chk("idle.tag", write_tag_array, 0);
    chk("idle.wda", write_data_array, 0);
  endtask

  // 4 words of 4 bytes, miss 0x00F7: block base 0x00F0.
  task automatic run_small();
    int  rets;
    bit  v;
    @(negedge clk);
    s_miss = 1'b1; s_addr = 16'h00F7; s_valid = 1'b0;
    #2;
    chk("w4.accept.busy", s_busy, 1);
    @(posedge clk);
    rets = 0;
    for (int j = 0; j < 20 && rets < 4; j++) begin
      @(negedge clk);
      s_miss = 1'b0; s_addr = 16'($urandom);
      v = (j >= 1) && (j <= 4);
      s_valid = v;
      #2;
      chk("w4.rd", s_rd, (j < 4) ? 1 : 0);
      if (j < 4) chk("w4.maddr", s_maddr, 32'h00F0 + j * 4);
      chk("w4.wda", s_wda, v);
      if (v) chk("w4.caddr", s_caddr, 32'h00F0 + rets * 4);
      if (v) rets++;
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    chk("w4.done", s_done, 1);
    chk("w4.tag", s_tag, 1);
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("w4.idle.busy", s_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0; miss_address = '0; victim_dirty = 1'b0; victim_address = '0;
    memory_data_valid = 1'b0;
    s_miss = 1'b0; s_addr = '0; s_vdirty = 1'b0; s_vaddr = '0; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk_all_zero("reset");
    rst = 1'b0;

    run_miss(16'h1234, 16'hA238, 1'b1, 0, 1'b0, 0);
    run_miss(16'h1234, 16'h0000, 1'b0, 1, 1'b0, 0);
    run_miss(16'($urandom), 16'($urandom), 1'b1, 2, 1'b0, 3);
    run_miss(16'h1234, 16'hA238, 1'b0, 0, 1'b0, 0);
    run_miss(16'h1234, 16'h5678, 1'b1, 2, 1'b1, 0);
    for (int t = 0; t < 10; t++) begin
      run_miss(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
               1'($urandom), 0);
    end
    run_small();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: byte-address width.
REQ-002 SHALL have parameter WORDS, default 8: words per cache block; power of two, at least 2.
REQ-003 SHALL have parameter WORD_BYTES, default 2: bytes per word; power of two.
REQ-004 SHALL have port clk, input, 1: rising-edge clock; the block has one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port miss_detected, input, 1: tag-match logic reports a miss.
REQ-007 SHALL have port miss_address, input, ADDR_W: address that missed.
REQ-008 SHALL have port victim_dirty, input, 1: the line being replaced is dirty.
REQ-009 SHALL have port victim_address, input, ADDR_W: any byte address within the victim block.
REQ-010 SHALL have port memory_data_valid, input, 1: one read word is returning on the memory bus.
REQ-011 SHALL have port fsm_busy, output, 1: pipeline stall.
REQ-012 SHALL have port mem_rd_req, output, 1: read request at main_memory_address.
REQ-013 SHALL have port mem_wr_req, output, 1: write request at main_memory_address.
REQ-014 SHALL have port main_memory_address, output, ADDR_W: memory-side word address.
REQ-015 SHALL have port memory_address, output, ADDR_W: cache-side word address (fill write, or victim read).
REQ-016 SHALL have port write_data_array, output, 1: cache data write enable.
REQ-017 SHALL have port write_tag_array, output, 1: cache tag write enable.
REQ-018 SHALL have port fill_done, output, 1: one-cycle completion pulse.

Function
REQ-019 Block base addresses SHALL be formed by zeroing the low log2(WORDS*WORD_BYTES) bits; word i address = base + i*WORD_BYTES.
REQ-020 States SHALL be IDLE, WB, FILL and DONE.
REQ-021 In IDLE, miss_detected=1 SHALL do all of the following: assert fsm_busy combinationally; latch miss_address, victim_address and victim_dirty; go to WB if dirty and write-back is compiled in, else go to FILL.
REQ-022 Latched addresses SHALL be used throughout; input changes after the latch SHALL have no effect.
REQ-023 FILL: the issue counter SHALL assert mem_rd_req every cycle while iss_cnt < WORDS, with main_memory_address = miss base + iss_cnt*WORD_BYTES, incrementing each cycle.
REQ-024 FILL: the return counter SHALL count memory_data_valid; each valid while ret_cnt < WORDS SHALL assert write_data_array with memory_address = miss base + ret_cnt*WORD_BYTES.
REQ-025 Returns SHALL be accepted in any cycle of FILL, including before issue completes; gaps in memory_data_valid SHALL be tolerated.
REQ-026 The cycle that accepts the WORDS-th return SHALL move the block to DONE.
REQ-027 DONE SHALL assert write_tag_array and fill_done for exactly one cycle, keep fsm_busy high, then go to IDLE.
REQ-028 fsm_busy SHALL be high in WB, FILL and DONE.
REQ-029 miss_detected SHALL be ignored outside IDLE; memory_data_valid SHALL be ignored outside FILL.
REQ-030 Both counters SHALL be log2(WORDS)+1 bits wide and SHALL clear on entry to FILL and on entry to WB.

Reset
REQ-031 rst SHALL asynchronously force IDLE, clear counters and latches, and drive every output to 0, including mid-WB and mid-FILL.

Configuration
REQ-032 With CACHE_FILL_WB_EN defined, WB SHALL assert mem_wr_req for WORDS consecutive cycles, with:
- main_memory_address = victim base + cnt*WORD_BYTES;
- memory_address = miss base + cnt*WORD_BYTES.
It SHALL then enter FILL.
REQ-033 Without CACHE_FILL_WB_EN, WB SHALL be unreachable, mem_wr_req SHALL be tied 0, and the victim inputs SHALL be ignored.

Structure
REQ-034 Shared package cache_pkg SHALL hold the state typedef and the default ADDR_W, WORDS and WORD_BYTES constants.
REQ-035 The issue and return counters SHALL be instances of one sub-module, cache_word_counter (clear, enable, parametrised width).

Verification
REQ-036 Defaults, miss_address=0x1234, data returns 4 cycles after each read → mem_rd_req on 0x1230..0x123E in 8 consecutive cycles; 8 write_data_array pulses on 0x1230..0x123E; then one write_tag_array/fill_done cycle.
REQ-037 memory_data_valid with gaps (pattern 1,0,0,1,...) → writes occur only on valid cycles, in order; DONE follows the 8th valid.
REQ-038 WB_EN, victim_dirty=1, victim_address=0xA238, miss 0x1234 → 8 mem_wr_req on 0xA230..0xA23E, memory_address 0x1230..0x123E, then normal fill.
REQ-039 rst after 3 fill words → all outputs 0 next sample; a new miss restarts at word 0.
REQ-040 miss_address changed and miss_detected pulsed mid-fill → no effect on addresses or state.
REQ-041 WORDS=4, WORD_BYTES=4, miss 0x00F7 → reads on 0x00F0, 0x00F4, 0x00F8, 0x00FC; 4 writes; then DONE.
